// File: rtl/odd_count_arbiter.sv
// Round-robin arbiter sharing one odd-value step counter (1,3,5,7,9) between two requesters.
// Optional pause input enabled by defining ODD_ARB_PAUSE_EN.
module odd_count_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              reset,
`ifdef ODD_ARB_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [1:0]        req,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [3:0]        Count,
  output logic              count_valid,
  output logic [1:0]        done,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds req until it sees done on its bit; req and
  // steps are sampled only on the grant edge, so later changes are ignored.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ZERO = '0;

  state_t            state_q;
  logic [1:0]        grant_q;
  logic              busy_q;
  logic [3:0]        count_q;
  logic [3:0]        count_d;
  logic [1:0]        done_q;
  logic [STEP_W-1:0] remaining_q;
  logic              ptr_q;

  logic              pause_w;
  logic              win_idx;
  logic [1:0]        win_onehot;
  logic [STEP_W-1:0] win_steps;

`ifdef ODD_ARB_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  always_comb begin
    count_d    = (count_q == 4'd9) ? 4'd1 : count_q + 4'd2;
    win_idx    = 1'b0;
    if (req == 2'b11) begin
      win_idx = ptr_q;
    end else if (req == 2'b10) begin
      win_idx = 1'b1;
    end
    win_onehot = win_idx ? 2'b10 : 2'b01;
    win_steps  = win_idx ? steps1 : steps0;
  end

  // ptr_q = 0 favours requester 0 when both request.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      busy_q      <= 1'b0;
      count_q     <= 4'd1;
      done_q      <= 2'b00;
      remaining_q <= STEP_ZERO;
      ptr_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 2'b00;
          if (req != 2'b00) begin
            grant_q     <= win_onehot;
            busy_q      <= 1'b1;
            remaining_q <= win_steps;
            if (win_steps == STEP_ZERO) begin
              state_q <= DONE;
              done_q  <= win_onehot;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (!pause_w) begin
            count_q     <= count_d;
            remaining_q <= remaining_q - STEP_ONE;
            if (remaining_q == STEP_ONE) begin
              state_q <= DONE;
              done_q  <= grant_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 2'b00;
          ptr_q   <= grant_q[0];
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 2'b00;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign Count       = count_q;
  assign done        = done_q;
  assign count_valid = (state_q == RUN) && !pause_w;
  assign dbg_state   = state_q;

endmodule
